osg_param_bank: RTL and testbench
=================================

OSG_PARAM_BANK -- requirements
Module: osg_param_bank

Interface
REQ-001 SHALL have parameter CH_NUM, default 16, number of pulse channels (1..32).
REQ-002 SHALL have parameter DUR_W, default 16, width of each duration/delay field (9..16).
REQ-003 SHALL have parameter REC_B, fixed 7, bytes per channel record; address map size ADDR_MAX = 1 + REC_B*CH_NUM.
REQ-004 SHALL have port clk_CFG, input, 1, the only clock; all logic on rising edge.
REQ-005 SHALL have port rst_CFG, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port in, input, 8, write data byte.
REQ-007 SHALL have port w_addr, input, 8, write byte address.
REQ-008 SHALL have port write, input, 1, active-low write strobe, sampled per cycle.
REQ-009 SHALL have ports PL_drt, DL_del, output, CH_NUM*DUR_W, active pulse length and delay, channel c at bits [c*DUR_W +: DUR_W].
REQ-010 SHALL have ports Mult_PL, Mult_DL, output, CH_NUM*5, active multipliers.
REQ-011 SHALL have port ch_type_start, output, CH_NUM*4, active start type.
REQ-012 SHALL have port pc_start, output, 1, one-cycle start pulse.
REQ-013 SHALL have port busy, output, 1, high while FSM not IDLE.
REQ-014 SHALL have port addr_err, output, 1, sticky out-of-range write flag.

Function
REQ-015 SHALL store bytes written to addresses 1..ADDR_MAX-1 in a shadow array; address 0 is the command register, not stored.
REQ-016 SHALL map channel c record at base 1+7c: +0 type, +1 Mult_DL, +2 DL hi, +3 DL lo, +4 Mult_PL, +5 PL hi, +6 PL lo.
REQ-017 SHALL form DUR_W fields as {hi,lo}[DUR_W-1:0]; multipliers take byte[4:0]; type takes byte[3:0].
REQ-018 SHALL drive active outputs only from the active register set, never combinationally from shadow.
REQ-019 SHALL set addr_err on any write with w_addr >= ADDR_MAX; write discarded; cleared only by command 0x00 or reset.
REQ-020 SHALL implement FSM IDLE, COMMIT, FIRE.
REQ-021 SHALL on command 0xA5 in IDLE go to COMMIT; COMMIT copies whole shadow to active in one cycle, then IDLE.
REQ-022 SHALL on command 0xFF in IDLE go to COMMIT, then FIRE; FIRE asserts pc_start exactly one cycle, then IDLE.
REQ-023 SHALL give pc_start latency of 2 cycles after the edge sampling the 0xFF write; active outputs update 1 cycle after that edge.
REQ-024 SHALL ignore commands received while busy; shadow data writes remain accepted in every state.
REQ-025 SHALL, on same-cycle data write and COMMIT, copy pre-write shadow contents; new byte lands in shadow only.
REQ-026 SHALL treat other command values as no-op.

Reset
REQ-027 SHALL on rst_CFG clear shadow, active set, pc_start, busy, addr_err, FSM to IDLE, asynchronously.
REQ-028 SHALL on reset mid-COMMIT or mid-FIRE suppress the pending pc_start and keep active set zero.

Configuration
REQ-029 SHALL with OSG_PARAM_READBACK_EN defined add input r_addr (8) and output r_data (8): shadow byte at r_addr one cycle later, 0x00 for address 0 or out of range.
REQ-030 SHALL without OSG_PARAM_READBACK_EN have no r_addr/r_data ports and no read mux.

Structure
REQ-031 SHALL place record byte offsets, command codes (0x00, 0xA5, 0xFF) and FSM state encoding in shared package osg_pkg.
REQ-032 SHALL contain one sub-module osg_rec_unpack converting 7 record bytes to typed channel fields, instantiated CH_NUM times.

Verification
REQ-033 SHALL cover: write ch0 PL hi/lo=0x12/0x34, no command -> PL_drt[15:0] stays 0x0000.
REQ-034 SHALL cover: then command 0xA5 -> PL_drt[15:0]=0x1234 next cycle, pc_start never high.
REQ-035 SHALL cover: command 0xFF -> busy 2 cycles, pc_start high exactly on cycle 2 after write.
REQ-036 SHALL cover: write w_addr=113 at CH_NUM=16 -> addr_err=1, shadow unchanged; command 0x00 -> addr_err=0.
REQ-037 SHALL cover: command 0xA5 during FIRE -> ignored, no second COMMIT.
REQ-038 SHALL cover: rst_CFG pulsed in COMMIT after 0xFF -> pc_start never asserts, all outputs 0.

Source files
------------

// File: rtl/osg_pkg.sv
// Shared definitions for the OSG parameter bank: record layout, command codes
// and controller state encoding.
package osg_pkg;

  // Bytes per channel record in the shadow address map.
  localparam int unsigned REC_BYTES = 7;

  // Byte offsets inside one channel record (record base = 1 + REC_BYTES*c).
  localparam int unsigned OFF_TYPE    = 0;
  localparam int unsigned OFF_MULT_DL = 1;
  localparam int unsigned OFF_DL_HI   = 2;
  localparam int unsigned OFF_DL_LO   = 3;
  localparam int unsigned OFF_MULT_PL = 4;
  localparam int unsigned OFF_PL_HI   = 5;
  localparam int unsigned OFF_PL_LO   = 6;

  // Command codes written to address 0.
  localparam logic [7:0] CMD_CLR_ERR = 8'h00;
  localparam logic [7:0] CMD_COMMIT  = 8'hA5;
  localparam logic [7:0] CMD_FIRE    = 8'hFF;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_COMMIT = 2'd1,
    ST_FIRE   = 2'd2
  } osg_state_t;

endpackage

// File: rtl/osg_rec_unpack.sv
// Splits one 7-byte channel record into its typed fields (pure combinational).
module osg_rec_unpack
  import osg_pkg::*;
#(
  parameter int unsigned DUR_W = 16
) (
  input  logic [7:0]       i_type,
  input  logic [7:0]       i_mult_dl,
  input  logic [7:0]       i_dl_hi,
  input  logic [7:0]       i_dl_lo,
  input  logic [7:0]       i_mult_pl,
  input  logic [7:0]       i_pl_hi,
  input  logic [7:0]       i_pl_lo,
  output logic [3:0]       o_type_c,
  output logic [4:0]       o_mult_dl_c,
  output logic [DUR_W-1:0] o_dl_c,
  output logic [4:0]       o_mult_pl_c,
  output logic [DUR_W-1:0] o_pl_c
);

  logic [15:0] w_dl_full;
  logic [15:0] w_pl_full;
  logic        w_unused_bits;

  // Durations are big-endian byte pairs truncated to the field width.
  assign w_dl_full   = {i_dl_hi, i_dl_lo};
  assign w_pl_full   = {i_pl_hi, i_pl_lo};
  assign o_dl_c      = w_dl_full[DUR_W-1:0];
  assign o_pl_c      = w_pl_full[DUR_W-1:0];
  assign o_type_c    = i_type[3:0];
  assign o_mult_dl_c = i_mult_dl[4:0];
  assign o_mult_pl_c = i_mult_pl[4:0];

  // Upper record bits carry no meaning for the channel fields.
  assign w_unused_bits = ^{i_type[7:4], i_mult_dl[7:5], i_mult_pl[7:5],
                           w_dl_full, w_pl_full};

endmodule

// File: rtl/osg_param_bank.sv
// Double-buffered pulse-channel parameter bank. Byte writes land in a shadow
// array; command 0xA5 copies shadow to the active set, 0xFF copies and then
// emits a one-cycle pc_start. Optional readback port: OSG_PARAM_READBACK_EN.
module osg_param_bank
  import osg_pkg::*;
#(
  parameter int unsigned CH_NUM = 16,
  parameter int unsigned DUR_W  = 16,
  parameter int unsigned REC_B  = REC_BYTES
) (
  input  logic                    clk_CFG,
  input  logic                    rst_CFG,
  input  logic [7:0]              in,
  input  logic [7:0]              w_addr,
  input  logic                    write,
`ifdef OSG_PARAM_READBACK_EN
  input  logic [7:0]              r_addr,
  output logic [7:0]              r_data,
`endif
  output logic [CH_NUM*DUR_W-1:0] PL_drt,
  output logic [CH_NUM*DUR_W-1:0] DL_del,
  output logic [CH_NUM*5-1:0]     Mult_PL,
  output logic [CH_NUM*5-1:0]     Mult_DL,
  output logic [CH_NUM*4-1:0]     ch_type_start,
  output logic                    pc_start,
  output logic                    busy,
  output logic                    addr_err
);

  localparam int unsigned ADDR_MAX   = 1 + REC_B * CH_NUM;
  localparam int unsigned SHADOW_N   = ADDR_MAX - 1;
  localparam logic [8:0]  ADDR_MAX_W = 9'(ADDR_MAX);

  logic [7:0] r_shadow [SHADOW_N];

  logic w_wr_en;
  logic w_is_cmd;
  logic w_in_range;
  logic w_err_wr;

  logic [CH_NUM*DUR_W-1:0] w_pl_drt;
  logic [CH_NUM*DUR_W-1:0] w_dl_del;
  logic [CH_NUM*5-1:0]     w_mult_pl;
  logic [CH_NUM*5-1:0]     w_mult_dl;
  logic [CH_NUM*4-1:0]     w_type;

  osg_state_t              r_state;
  logic                    r_fire_pend;
  logic                    r_busy;
  logic                    r_pc_start;
  logic                    r_addr_err;
  logic [CH_NUM*DUR_W-1:0] r_pl_drt;
  logic [CH_NUM*DUR_W-1:0] r_dl_del;
  logic [CH_NUM*5-1:0]     r_mult_pl;
  logic [CH_NUM*5-1:0]     r_mult_dl;
  logic [CH_NUM*4-1:0]     r_type;

  // Write strobe decode: address 0 is the command register.
  assign w_wr_en    = ~write;
  assign w_in_range = {1'b0, w_addr} < ADDR_MAX_W;
  assign w_is_cmd   = w_wr_en && (w_addr == 8'd0);
  assign w_err_wr   = w_wr_en && !w_in_range;

  // Shadow array: data writes accepted in every controller state.
  always_ff @(posedge clk_CFG or posedge rst_CFG) begin
    if (rst_CFG) begin
      for (int unsigned i = 0; i < SHADOW_N; i++) r_shadow[i] <= 8'h00;
    end else begin
      for (int unsigned i = 0; i < SHADOW_N; i++) begin
        if (w_wr_en && (w_addr == 8'(i + 1))) r_shadow[i] <= in;
      end
    end
  end

  // Per-channel view of the shadow records.
  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    localparam int unsigned BASE = c * REC_B;
    osg_rec_unpack #(.DUR_W(DUR_W)) u_unpack (
      .i_type      (r_shadow[BASE + OFF_TYPE]),
      .i_mult_dl   (r_shadow[BASE + OFF_MULT_DL]),
      .i_dl_hi     (r_shadow[BASE + OFF_DL_HI]),
      .i_dl_lo     (r_shadow[BASE + OFF_DL_LO]),
      .i_mult_pl   (r_shadow[BASE + OFF_MULT_PL]),
      .i_pl_hi     (r_shadow[BASE + OFF_PL_HI]),
      .i_pl_lo     (r_shadow[BASE + OFF_PL_LO]),
      .o_type_c    (w_type[c*4 +: 4]),
      .o_mult_dl_c (w_mult_dl[c*5 +: 5]),
      .o_dl_c      (w_dl_del[c*DUR_W +: DUR_W]),
      .o_mult_pl_c (w_mult_pl[c*5 +: 5]),
      .o_pl_c      (w_pl_drt[c*DUR_W +: DUR_W])
    );
  end

  // Command FSM, active register set, status flags.
  always_ff @(posedge clk_CFG or posedge rst_CFG) begin
    if (rst_CFG) begin
      r_state     <= ST_IDLE;
      r_fire_pend <= 1'b0;
      r_busy      <= 1'b0;
      r_pc_start  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_pl_drt    <= '0;
      r_dl_del    <= '0;
      r_mult_pl   <= '0;
      r_mult_dl   <= '0;
      r_type      <= '0;
    end else begin
      r_pc_start <= 1'b0;
      if (w_err_wr) r_addr_err <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_is_cmd) begin
            if (in == CMD_COMMIT) begin
              r_state     <= ST_COMMIT;
              r_fire_pend <= 1'b0;
              r_busy      <= 1'b1;
            end else if (in == CMD_FIRE) begin
              r_state     <= ST_COMMIT;
              r_fire_pend <= 1'b1;
              r_busy      <= 1'b1;
            end else if (in == CMD_CLR_ERR) begin
              r_addr_err  <= 1'b0;
            end
          end
        end
        ST_COMMIT: begin
          // Non-blocking copy: a same-cycle shadow write is not captured.
          r_pl_drt  <= w_pl_drt;
          r_dl_del  <= w_dl_del;
          r_mult_pl <= w_mult_pl;
          r_mult_dl <= w_mult_dl;
          r_type    <= w_type;
          if (r_fire_pend) begin
            r_state <= ST_FIRE;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_FIRE: begin
          r_pc_start  <= 1'b1;
          r_fire_pend <= 1'b0;
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign PL_drt        = r_pl_drt;
  assign DL_del        = r_dl_del;
  assign Mult_PL       = r_mult_pl;
  assign Mult_DL       = r_mult_dl;
  assign ch_type_start = r_type;
  assign pc_start      = r_pc_start;
  assign busy          = r_busy;
  assign addr_err      = r_addr_err;

`ifdef OSG_PARAM_READBACK_EN
  logic [7:0] r_rd_data;

  // Registered shadow readback; address 0 and out-of-range read as zero.
  always_ff @(posedge clk_CFG or posedge rst_CFG) begin
    if (rst_CFG) begin
      r_rd_data <= 8'h00;
    end else begin
      r_rd_data <= 8'h00;
      for (int unsigned i = 0; i < SHADOW_N; i++) begin
        if (r_addr == 8'(i + 1)) r_rd_data <= r_shadow[i];
      end
    end
  end

  assign r_data = r_rd_data;
`endif

endmodule

// File: tb/tb_osg_param_bank.sv
// Bench for osg_param_bank: table-driven register/command vectors plus
// hand-written fire, busy-command and reset-abort sequences.
module tb_osg_param_bank;

  localparam int unsigned CH_NUM = 16;
  localparam int unsigned DUR_W  = 16;

  logic                    clk_CFG = 1'b0;
  logic                    rst_CFG;
  logic [7:0]              in;
  logic [7:0]              w_addr;
  logic                    write;
  logic [CH_NUM*DUR_W-1:0] PL_drt;
  logic [CH_NUM*DUR_W-1:0] DL_del;
  logic [CH_NUM*5-1:0]     Mult_PL;
  logic [CH_NUM*5-1:0]     Mult_DL;
  logic [CH_NUM*4-1:0]     ch_type_start;
  logic                    pc_start;
  logic                    busy;
  logic                    addr_err;
`ifdef OSG_PARAM_READBACK_EN
  logic [7:0]              r_addr;
  logic [7:0]              r_data;
`endif

  osg_param_bank #(.CH_NUM(CH_NUM), .DUR_W(DUR_W), .REC_B(7)) dut (
    .clk_CFG       (clk_CFG),
    .rst_CFG       (rst_CFG),
    .in            (in),
    .w_addr        (w_addr),
    .write         (write),
`ifdef OSG_PARAM_READBACK_EN
    .r_addr        (r_addr),
    .r_data        (r_data),
`endif
    .PL_drt        (PL_drt),
    .DL_del        (DL_del),
    .Mult_PL       (Mult_PL),
    .Mult_DL       (Mult_DL),
    .ch_type_start (ch_type_start),
    .pc_start      (pc_start),
    .busy          (busy),
    .addr_err      (addr_err)
  );

  always #5 clk_CFG = ~clk_CFG;

  typedef struct {
    logic [15:0] pl0;
    logic [15:0] dl0;
    logic [15:0] pl15;
    logic [4:0]  mpl0;
    logic [4:0]  mdl0;
    logic [3:0]  ty0;
    logic        err;
    logic        bsy;
    logic        pc;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         settle;
    exp_t       e;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  int   pc_seen = 0;
  exp_t exp_q[$];
  exp_t cur;
  vec_t vecs[16];

  // Count every pc_start cycle over the whole run.
  always @(negedge clk_CFG) if (pc_start === 1'b1) pc_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it against the DUT now.
  task automatic sb_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_pl0"},  32'(PL_drt[15:0]),        32'(e.pl0));
    chk({tag, "_dl0"},  32'(DL_del[15:0]),        32'(e.dl0));
    chk({tag, "_pl15"}, 32'(PL_drt[15*16 +: 16]), 32'(e.pl15));
    chk({tag, "_mpl0"}, 32'(Mult_PL[4:0]),        32'(e.mpl0));
    chk({tag, "_mdl0"}, 32'(Mult_DL[4:0]),        32'(e.mdl0));
    chk({tag, "_ty0"},  32'(ch_type_start[3:0]),  32'(e.ty0));
    chk({tag, "_err"},  32'(addr_err),            32'(e.err));
    chk({tag, "_busy"}, 32'(busy),                32'(e.bsy));
    chk({tag, "_pc"},   32'(pc_start),            32'(e.pc));
  endtask

  // One-cycle write; called at a falling edge, returns half a cycle after
  // the rising edge that sampled it.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    write  = 1'b0;
    w_addr = a;
    in     = d;
    @(negedge clk_CFG);
    write  = 1'b1;
  endtask

  function automatic exp_t mk(input logic [15:0] pl0, input logic [15:0] dl0,
                              input logic [15:0] pl15, input logic [4:0] mpl,
                              input logic [4:0] mdl, input logic [3:0] ty,
                              input logic err, input logic bsy, input logic pc);
    exp_t e;
    e.pl0 = pl0; e.dl0 = dl0; e.pl15 = pl15; e.mpl0 = mpl; e.mdl0 = mdl;
    e.ty0 = ty; e.err = err; e.bsy = bsy; e.pc = pc;
    return e;
  endfunction

  function automatic vec_t mv(input logic [7:0] a, input logic [7:0] d,
                              input int settle, input exp_t e);
    vec_t v;
    v.addr = a; v.data = d; v.settle = settle; v.e = e;
    return v;
  endfunction

  initial begin
    exp_t z, full;
    z    = mk(16'h0, 16'h0, 16'h0, 5'h0, 5'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    full = mk(16'h1234, 16'hABCD, 16'h5AC3, 5'h07, 5'h1F, 4'hB, 1'b0, 1'b0, 1'b0);

    // Shadow writes stay invisible until commit; then command/error handling.
    vecs[0]  = mv(8'd6,   8'h12, 1, z);
    vecs[1]  = mv(8'd7,   8'h34, 1, z);
    vecs[2]  = mv(8'd1,   8'h0B, 1, z);
    vecs[3]  = mv(8'd2,   8'hFF, 1, z);
    vecs[4]  = mv(8'd3,   8'hAB, 1, z);
    vecs[5]  = mv(8'd4,   8'hCD, 1, z);
    vecs[6]  = mv(8'd5,   8'h27, 1, z);
    vecs[7]  = mv(8'd111, 8'h5A, 1, z);
    vecs[8]  = mv(8'd112, 8'hC3, 1, z);
    vecs[9]  = mv(8'd0,   8'hA5, 0, mk(16'h0, 16'h0, 16'h0, 5'h0, 5'h0, 4'h0, 1'b0, 1'b1, 1'b0));
    vecs[10] = mv(8'd0,   8'h00, 0, full);
    vecs[11] = mv(8'd113, 8'h77, 1, mk(16'h1234, 16'hABCD, 16'h5AC3, 5'h07, 5'h1F, 4'hB, 1'b1, 1'b0, 1'b0));
    vecs[12] = mv(8'd0,   8'h42, 0, mk(16'h1234, 16'hABCD, 16'h5AC3, 5'h07, 5'h1F, 4'hB, 1'b1, 1'b0, 1'b0));
    vecs[13] = mv(8'd0,   8'h00, 1, full);
    vecs[14] = mv(8'd255, 8'h01, 0, mk(16'h1234, 16'hABCD, 16'h5AC3, 5'h07, 5'h1F, 4'hB, 1'b1, 1'b0, 1'b0));
    vecs[15] = mv(8'd0,   8'h00, 0, full);

    rst_CFG = 1'b1;
    write   = 1'b1;
    in      = 8'h00;
    w_addr  = 8'h00;
`ifdef OSG_PARAM_READBACK_EN
    r_addr  = 8'h00;
`endif
    #1;
    exp_q.push_back(z);
    sb_check("reset");
    repeat (2) @(negedge clk_CFG);
    rst_CFG = 1'b0;
    @(negedge clk_CFG);

    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(vecs[i].e);
      wr(vecs[i].addr, vecs[i].data);
      repeat (vecs[i].settle) @(negedge clk_CFG);
      sb_check($sformatf("vec%0d", i));
    end
    cur = full;

`ifdef OSG_PARAM_READBACK_EN
    r_addr = 8'd7;   @(negedge clk_CFG); chk("rd_a7",   32'(r_data), 32'h34);
    r_addr = 8'd0;   @(negedge clk_CFG); chk("rd_a0",   32'(r_data), 32'h00);
    r_addr = 8'd113; @(negedge clk_CFG); chk("rd_a113", 32'(r_data), 32'h00);
`endif

    // Fire: busy two cycles, actives one cycle after the sampling edge,
    // pc_start on the second cycle.
    wr(8'd6, 8'hBE);
    wr(8'd7, 8'hEF);
    exp_q.push_back(cur);
    sb_check("fire_pre");
    cur.bsy = 1'b1;
    exp_q.push_back(cur);
    cur.pl0 = 16'hBEEF;
    exp_q.push_back(cur);
    cur.bsy = 1'b0; cur.pc = 1'b1;
    exp_q.push_back(cur);
    cur.pc = 1'b0;
    exp_q.push_back(cur);
    wr(8'd0, 8'hFF);
    sb_check("fire_c1");
    @(negedge clk_CFG); sb_check("fire_c2");
    @(negedge clk_CFG); sb_check("fire_c3");
    @(negedge clk_CFG); sb_check("fire_c4");

    // Write during COMMIT lands only in shadow; 0xA5 during FIRE is ignored.
    wr(8'd7, 8'h11);
    cur.bsy = 1'b1;
    exp_q.push_back(cur);
    wr(8'd0, 8'hFF);
    sb_check("busy_c1");
    cur.pl0 = 16'hBE11;
    exp_q.push_back(cur);
    wr(8'd7, 8'h22);
    sb_check("busy_c2");
    cur.bsy = 1'b0; cur.pc = 1'b1;
    exp_q.push_back(cur);
    wr(8'd0, 8'hA5);
    sb_check("busy_c3");
    cur.pc = 1'b0;
    exp_q.push_back(cur);
    @(negedge clk_CFG); sb_check("busy_c4");
    cur.bsy = 1'b1;
    exp_q.push_back(cur);
    wr(8'd0, 8'hA5);
    sb_check("late_c1");
    cur.bsy = 1'b0; cur.pl0 = 16'hBE22;
    exp_q.push_back(cur);
    @(negedge clk_CFG); sb_check("late_c2");
    chk("pc_count_mid", 32'(pc_seen), 32'd2);

    // Reset during COMMIT after 0xFF aborts the pending start.
    wr(8'd200, 8'h00);
    chk("err_set", 32'(addr_err), 32'd1);
    wr(8'd0, 8'hFF);
    chk("abort_busy", 32'(busy), 32'd1);
    rst_CFG = 1'b1;
    #1;
    exp_q.push_back(z);
    sb_check("abort_rst");
    @(negedge clk_CFG);
    rst_CFG = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(z);
      sb_check($sformatf("abort_c%0d", i));
      @(negedge clk_CFG);
    end
    chk("pc_count_end", 32'(pc_seen), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
